mdio_master: RTL and testbench

Parametrised MDIO (IEEE 802.3 Clause 22/45) management master. It generates MDC from i_clk and serialises complete management frames on io_mdio: preamble, ST, OP, PHYAD/PRTAD, REGAD/DEVAD, TA and DATA. Commands arrive as field-level inputs through a valid/ready handshake. Read data, completion and turnaround-error status are returned as pulses and flags. It sits between the MAC control/register logic and the external PHY management pins.

---
 rtl/mdio_master.sv | 180 ++++++++++++++++++
 tb/tb_mdio_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// MDIO (Clause 22/45) management master: divides i_clk down to MDC and
// serialises one complete management frame per accepted command.
module mdio_master #(
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter int unsigned CLAUSE45_EN  = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_clause45,
    input  logic [1:0]  i_op,
    input  logic [4:0]  i_phyad,
    input  logic [4:0]  i_regad,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_ta_err,
    output logic        o_mdc,
    inout  wire         io_mdio
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DIV_LAST = CLK_DIV - 1;
    localparam int unsigned DIV_PEN  = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;
    localparam int unsigned PRE_LAST = (PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_GAP
    } state_t;

    localparam state_t FIRST_STATE = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;

    state_t             state;
    state_t             nxt_state;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [5:0]         nxt_cnt;
    logic [13:0]        hdr;
    logic [15:0]        wdata;
    logic               is_read;
    logic [15:0]        shift;
    logic               mdio_oe;
    logic               mdio_out;

    logic               half_end;
    logic               bit_end;
    logic               penult;
    logic               accept;
    logic [13:0]        new_hdr;

    assign io_mdio  = mdio_oe ? mdio_out : 1'bz;

    // o_mdc doubles as the half-period phase: low half first, high half second
    assign half_end = (div_cnt == DIV_W'(DIV_LAST));
    assign bit_end  = half_end && o_mdc;
    assign penult   = (CLK_DIV > 1) ? (o_mdc && (div_cnt == DIV_W'(DIV_PEN))) : !o_mdc;
    assign accept   = i_cmd_valid && o_cmd_ready;
    assign new_hdr  = {((CLAUSE45_EN != 0) && i_clause45) ? 2'b00 : 2'b01,
                       i_op, i_phyad, i_regad};

    // Output enable and value for a given bit of the frame
    function automatic logic [1:0] drive_bit(input state_t st, input logic [5:0] cnt,
                                             input logic [13:0] h, input logic [15:0] w,
                                             input logic rd);
        logic [1:0] r;
        r = 2'b00;
        case (st)
            S_PRE:   r = 2'b11;
            S_HDR:   r = {1'b1, h[4'(6'd13 - cnt)]};
            S_TA:    r = rd ? 2'b00 : {1'b1, ~cnt[0]};
            S_DATA:  r = rd ? 2'b00 : {1'b1, w[4'(6'd15 - cnt)]};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Field sequencing at each bit boundary
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt + 6'd1;
        case (state)
            S_PRE: if (bit_cnt == 6'(PRE_LAST)) begin
                nxt_state = S_HDR;
                nxt_cnt   = 6'd0;
            end
            S_HDR: if (bit_cnt == 6'd13) begin
                nxt_state = S_TA;
                nxt_cnt   = 6'd0;
            end
            S_TA: if (bit_cnt == 6'd1) begin
                nxt_state = S_DATA;
                nxt_cnt   = 6'd0;
            end
            S_DATA: if (bit_cnt == 6'd15) begin
                nxt_state = S_GAP;
                nxt_cnt   = 6'd0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            hdr           <= '0;
            wdata         <= '0;
            is_read       <= 1'b0;
            shift         <= '0;
            mdio_oe       <= 1'b0;
            mdio_out      <= 1'b0;
            o_cmd_ready   <= 1'b1;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_ta_err      <= 1'b0;
            o_mdc         <= 1'b0;
        end else begin
            o_done        <= 1'b0;
            o_rdata_valid <= 1'b0;
            if (accept) begin
                state       <= FIRST_STATE;
                div_cnt     <= '0;
                bit_cnt     <= '0;
                o_mdc       <= 1'b0;
                hdr         <= new_hdr;
                wdata       <= i_wdata;
                is_read     <= i_op[1];
                {mdio_oe, mdio_out} <= drive_bit(FIRST_STATE, 6'd0, new_hdr, i_wdata, i_op[1]);
                o_cmd_ready <= 1'b0;
                o_busy      <= 1'b1;
                o_ta_err    <= 1'b0;
            end else if (state != S_IDLE) begin
                div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
                if (half_end) begin
                    o_mdc <= ~o_mdc;
                end
                // PHY-driven bits are sampled on the MDC rising transition
                if (half_end && !o_mdc && is_read) begin
                    if (state == S_TA && bit_cnt == 6'd1) begin
                        o_ta_err <= io_mdio;
                    end
                    if (state == S_DATA) begin
                        shift <= {shift[14:0], io_mdio};
                    end
                end
                if (bit_end) begin
                    state   <= nxt_state;
                    bit_cnt <= nxt_cnt;
                    {mdio_oe, mdio_out} <= drive_bit(nxt_state, nxt_cnt, hdr, wdata, is_read);
                end
                // Completion is flagged in the last i_clk cycle of the gap bit
                if (state == S_GAP && penult) begin
                    o_done      <= 1'b1;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    if (is_read) begin
                        o_rdata       <= shift;
                        o_rdata_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: table of frames with hand-built MDIO bit
// streams, plus back-to-back and mid-frame reset sequences.
module tb_mdio_master;

    localparam int N0 = 260;   // (32 + 33) * 2 * 2
    localparam int N1 = 132;   // (0 + 33) * 2 * 2
    localparam int RDY = 5, BSY = 4, DNE = 3, RV = 2, TAE = 1, MDC = 0;

    typedef struct {
        logic        inst;
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        phy_on;
        logic [15:0] phy_data;
        logic [64:0] frame;
        int          nbits;
        logic [15:0] exp_rdata;
        logic        exp_ta;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        valid0, valid1;
    logic        c45;
    logic [1:0]  op;
    logic [4:0]  phyad, regad;
    logic [15:0] wdata;

    wire         mdio0, mdio1;
    logic        phy_en = 1'b0;
    logic        pull_low = 1'b0;
    logic        phy_oe = 1'b0;
    logic        phy_val = 1'b0;
    logic [15:0] phy_data = '0;

    logic        d0_ready, d0_busy, d0_done, d0_rv, d0_ta, d0_mdc;
    logic        d1_ready, d1_busy, d1_done, d1_rv, d1_ta, d1_mdc;
    logic [15:0] d0_rdata, d1_rdata;
    wire  [5:0]  st0 = {d0_ready, d0_busy, d0_done, d0_rv, d0_ta, d0_mdc};
    wire  [5:0]  st1 = {d1_ready, d1_busy, d1_done, d1_rv, d1_ta, d1_mdc};

    int checks = 0;
    int failures = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    pullup (mdio0);
    pullup (mdio1);
    assign mdio0 = (pull_low || (phy_en && phy_oe)) ? (phy_val && !pull_low) : 1'bz;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32), .CLAUSE45_EN(1)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(valid0), .o_cmd_ready(d0_ready),
        .i_clause45(c45), .i_op(op), .i_phyad(phyad), .i_regad(regad), .i_wdata(wdata),
        .o_busy(d0_busy), .o_done(d0_done), .o_rdata(d0_rdata), .o_rdata_valid(d0_rv),
        .o_ta_err(d0_ta), .o_mdc(d0_mdc), .io_mdio(mdio0));

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0), .CLAUSE45_EN(1)) dut_nopre (
        .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(valid1), .o_cmd_ready(d1_ready),
        .i_clause45(c45), .i_op(op), .i_phyad(phyad), .i_regad(regad), .i_wdata(wdata),
        .o_busy(d1_busy), .o_done(d1_done), .o_rdata(d1_rdata), .o_rdata_valid(d1_rv),
        .o_ta_err(d1_ta), .o_mdc(d1_mdc), .io_mdio(mdio1));

    // Bit capture on MDC rise; PHY model drives TA bit 2 and data after MDC falls
    logic        mdc0_q = 1'b0, mdc1_q = 1'b0;
    logic [64:0] cap0 = '0, cap1 = '0;
    int          n0 = 0, n1 = 0;

    always @(negedge clk) begin
        mdc0_q <= d0_mdc;
        mdc1_q <= d1_mdc;
        if (!d0_busy && !d0_done) begin
            cap0 <= '0;
            n0   <= 0;
        end else if (d0_mdc && !mdc0_q) begin
            cap0 <= {cap0[63:0], mdio0};
            n0   <= n0 + 1;
        end
        if (!d0_mdc && mdc0_q) begin
            if (n0 == 47) begin
                phy_oe  <= 1'b1;
                phy_val <= 1'b0;
            end else if (n0 >= 48 && n0 <= 63) begin
                phy_oe  <= 1'b1;
                phy_val <= phy_data[4'(63 - n0)];
            end else begin
                phy_oe  <= 1'b0;
            end
        end
        if (!d1_busy && !d1_done) begin
            cap1 <= '0;
            n1   <= 0;
        end else if (d1_mdc && !mdc1_q) begin
            cap1 <= {cap1[63:0], mdio1};
            n1   <= n1 + 1;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input logic inst, output int k, output bit ok);
        k  = 0;
        ok = 1'b0;
        while (k < 2000) begin
            if ((inst ? st1[DNE] : st0[DNE]) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        bit   ok;
        int   n;
        v        = vecs[idx];
        n        = v.inst ? N1 : N0;
        c45      = v.c45;
        op       = v.op;
        phyad    = v.phyad;
        regad    = v.regad;
        wdata    = v.wdata;
        phy_en   = v.phy_on;
        phy_data = v.phy_data;
        if (v.inst) valid1 = 1'b1;
        else        valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        chk($sformatf("v%0d_busy_after_accept", idx), v.inst ? st1[BSY] : st0[BSY], 1);
        chk($sformatf("v%0d_ready_after_accept", idx), v.inst ? st1[RDY] : st0[RDY], 0);
        wait_done(v.inst, k, ok);
        chk($sformatf("v%0d_done_seen", idx), ok, 1);
        if (ok) begin
            chk($sformatf("v%0d_latency", idx), k + 1, n);
            chk($sformatf("v%0d_rdata_valid", idx), v.inst ? st1[RV] : st0[RV], v.op[1]);
            chk($sformatf("v%0d_ready_at_done", idx), v.inst ? st1[RDY] : st0[RDY], 1);
            chk($sformatf("v%0d_busy_at_done", idx), v.inst ? st1[BSY] : st0[BSY], 0);
            chk($sformatf("v%0d_rdata", idx), v.inst ? d1_rdata : d0_rdata, v.exp_rdata);
            chk($sformatf("v%0d_ta_err", idx), v.inst ? st1[TAE] : st0[TAE], v.exp_ta);
            chk($sformatf("v%0d_nbits", idx), v.inst ? n1 : n0, v.nbits);
            chk($sformatf("v%0d_frame", idx), v.inst ? cap1 : cap0, v.frame);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", idx), v.inst ? st1[DNE] : st0[DNE], 0);
            chk($sformatf("v%0d_rv_one_cycle", idx), v.inst ? st1[RV] : st0[RV], 0);
        end
        phy_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int  k, k2, extra, dones_in_rst;
        bit  ok;

        vecs[0] = '{1'b0, 1'b0, 2'b01, 5'h03, 5'h00, 16'h1140, 1'b0, 16'h0000,
                    {32'hFFFF_FFFF, 14'b01_01_00011_00000, 2'b10, 16'h1140, 1'b1},
                    65, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'hBEEF,
                    {32'hFFFF_FFFF, 14'b01_10_00001_00010, 2'b10, 16'hBEEF, 1'b1},
                    65, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000,
                    {32'hFFFF_FFFF, 14'b01_10_00001_00010, 2'b11, 16'hFFFF, 1'b1},
                    65, 16'hFFFF, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 2'b01, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 16'h0000,
                    {32'hFFFF_FFFF, 14'b01_01_11111_11111, 2'b10, 16'hFFFF, 1'b1},
                    65, 16'hFFFF, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 2'b11, 5'h1F, 5'h1F, 16'h0000, 1'b1, 16'h0001,
                    {32'hFFFF_FFFF, 14'b00_11_11111_11111, 2'b10, 16'h0001, 1'b1},
                    65, 16'h0001, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'b00, 5'h05, 5'h01, 16'h0010, 1'b0, 16'h0000,
                    65'({14'b00_00_00101_00001, 2'b10, 16'h0010, 1'b1}),
                    33, 16'h0000, 1'b0};

        i_reset = 1'b1;
        valid0  = 1'b0;
        valid1  = 1'b0;
        c45     = 1'b0;
        op      = 2'b00;
        phyad   = '0;
        regad   = '0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", st0[RDY], 1);
        chk("rst_busy_done_rv_ta_mdc", {st0[BSY], st0[DNE], st0[RV], st0[TAE], st0[MDC]}, 0);
        chk("rst_rdata", d0_rdata, 16'h0000);
        chk("rst_mdio_not_low", mdio0, 1);
        pull_low = 1'b1;
        #1;
        chk("rst_mdio_not_high", mdio0, 0);
        pull_low = 1'b0;
        i_reset  = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            if (i == 2) begin
                chk("ta_err_held_idle", st0[TAE], 1);
            end
        end

        // Back-to-back with valid held, plus an ignored mid-frame pulse
        c45 = 1'b0; op = 2'b01; phyad = 5'h03; regad = 5'h00; wdata = 16'h1140;
        valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(1'b0, k, ok);
        chk("b2b_first_done", ok, 1);
        chk("b2b_first_latency", k + 1, N0);
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        chk("b2b_second_accepted", {st0[BSY], st0[RDY]}, 2'b10);
        repeat (100) @(negedge clk);
        valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        chk("b2b_mid_pulse_busy", st0[BSY], 1);
        wait_done(1'b0, k2, ok);
        chk("b2b_second_done", ok, 1);
        chk("b2b_second_latency", 102 + k2, N0);
        extra = 0;
        repeat (600) begin
            @(negedge clk);
            if (st0[DNE]) extra++;
        end
        chk("b2b_no_third_frame", extra, 0);
        chk("b2b_idle_ready", st0[RDY], 1);

        // Reset in the middle of the DATA field of a read
        c45 = 1'b0; op = 2'b10; phyad = 5'h01; regad = 5'h02;
        phy_en = 1'b1; phy_data = 16'hBEEF;
        valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        repeat (210) @(negedge clk);
        chk("midrst_in_frame", st0[BSY], 1);
        phy_en  = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("midrst_mdc_low", st0[MDC], 0);
        chk("midrst_ready", st0[RDY], 1);
        chk("midrst_busy", st0[BSY], 0);
        chk("midrst_mdio_not_low", mdio0, 1);
        pull_low = 1'b1;
        #1;
        chk("midrst_mdio_not_high", mdio0, 0);
        pull_low = 1'b0;
        dones_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (st0[DNE]) dones_in_rst++;
        end
        i_reset = 1'b0;
        @(negedge clk);
        if (st0[DNE]) dones_in_rst++;
        chk("midrst_no_done", dones_in_rst, 0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
